// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states and oversampling constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVS_RATE   = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator: one-cycle pulse every OVS_DIV clocks, restartable via clr.
// Latency: first tick OVS_DIV cycles after clr; no backpressure.
module uart_baud_tick #(
  parameter int OVS_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(OVS_DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 16'd0;
    end else if (cnt == LAST) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), 16x oversampled; byte appears one cycle after stop sample.
// Backpressure: single holding register with valid/ready; a byte completing while it is occupied is dropped (overrun).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [3:0] OVS_LAST = 4'(OVS_RATE - 1);
  localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  state_t     state, state_n;
  logic       rxd_m, rxd_s, rxd_d;
  logic [3:0] ovs, ovs_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n;
  logic       tick, tick_clr, done, ferr_n, perr_n;
  logic       mid_bit, mid_start;
`ifdef UART_RX_PARITY_EN
  logic       par_bad, par_bad_n;
`endif

  uart_baud_tick #(.OVS_DIV(OVS_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign mid_bit   = tick && (ovs == OVS_LAST);
  assign mid_start = tick && (ovs == MID_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      rxd_d     <= 1'b1;
      state     <= IDLE;
      ovs       <= 4'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rxd_m     <= rxd;
      rxd_s     <= rxd_m;
      rxd_d     <= rxd_s;
      state     <= state_n;
      ovs       <= ovs_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_n;
      parity_err <= perr_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    ovs_n    = ovs;
    bit_n    = bit_cnt;
    shift_n  = shift;
    tick_clr = 1'b0;
    done     = 1'b0;
    ferr_n   = 1'b0;
    perr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
`endif
    case (state)
      IDLE: begin
        ovs_n = 4'd0;
        bit_n = 3'd0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = 1'b0;
`endif
        if (rxd_d && !rxd_s) begin
          state_n  = START;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (tick) ovs_n = ovs + 4'd1;
        // A start bit that is high again at its midpoint was a glitch.
        if (mid_start) begin
          ovs_n   = 4'd0;
          state_n = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) ovs_n = ovs + 4'd1;
        if (mid_bit) begin
          shift_n = {rxd_s, shift[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) ovs_n = ovs + 4'd1;
        if (mid_bit) begin
          par_bad_n = (^shift) ^ rxd_s;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) ovs_n = ovs + 4'd1;
        if (mid_bit) begin
          state_n = IDLE;
          if (!rxd_s) begin
            ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            perr_n = 1'b1;
`endif
          end else begin
            done = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Completion coinciding with a handshake refills the register without overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
